mem_port_arbiter: RTL

- Shares the single-port unified instruction/data memory of the pipelined MIPS core between two requesters:
  - IF stage: instruction fetch, read-only.
  - MEM stage: load/store.
- Serialises accesses and tolerates multi-cycle memory latency.
- Its acks drive the pipeline stall logic: a stage stalls while its req is high and its ack is low.
- Sits inside TOP, between the pipeline registers and the memory.

---
 rtl/mem_port_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the MIPS core's single-port unified memory between instruction fetch and load/store.
// Data requests win by default; a streak counter bounds how long a waiting fetch can be starved.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);
  localparam int BW = DW / 8;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;
  localparam logic [3:0] MAXS    = 4'(MAX_D_STREAK);

  typedef struct packed {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  logic [1:0] state;
  logic [3:0] streak;
  logic       req_q;
  acc_t       acc;
  logic       d_win;

  // streak only reaches MAXS while a fetch waits, so it cannot overflow
  assign d_win = d_req && (!if_req || (streak < MAXS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      streak <= '0;
      req_q  <= 1'b0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_win) begin
            acc    <= '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
            req_q  <= 1'b1;
            state  <= D_BUSY;
            streak <= if_req ? streak + 4'd1 : 4'd0;
          end else if (if_req) begin
            acc.we   <= 1'b0;
            acc.be   <= '1;
            acc.addr <= if_addr;
            req_q    <= 1'b1;
            state    <= IF_BUSY;
            streak   <= '0;
          end
        end
        default: begin
          // address/data/byte-enables keep their last value once the access retires
          if (mem_ready) begin
            req_q  <= 1'b0;
            acc.we <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = acc.we;
  assign mem_be    = acc.be;
  assign mem_addr  = acc.addr;
  assign mem_wdata = acc.wdata;

  assign if_ack   = (state == IF_BUSY) && mem_ready;
  assign d_ack    = (state == D_BUSY) && mem_ready;
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign d_rdata  = d_ack ? mem_rdata : '0;
endmodule
